// File: rtl/vga_timing.sv
// VGA raster timing generator with a frame-synchronous 12-digit BCD word register.
// Define VGA_DOUBLE_BUFFER_EN to defer new words to the next frame wrap via a pending slot.
module vga_timing #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] numbers_in,
  input  logic        numbers_valid,
  output logic        numbers_ready,
  output logic [9:0]  sx,
  output logic [9:0]  sy,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        pix_stb,
  output logic        frame_start,
  output logic [47:0] numbers_concat
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW    = $clog2(CLK_DIV);

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0] HActive    = 10'(H_ACTIVE);
  localparam logic [9:0] VActive    = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncBeg   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncBeg   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      sx_q, sx_d, sy_q, sy_d;
  logic [47:0]     concat_q, concat_d;
  logic            h_last, v_last;

  always_comb begin
    pix_stb     = (div_q == DivLast);
    h_last      = (sx_q == HLast);
    v_last      = (sy_q == VLast);
    frame_start = pix_stb && h_last && v_last;
    div_d       = pix_stb ? '0 : div_q + 1'b1;
    sx_d        = sx_q;
    sy_d        = sy_q;
    if (pix_stb) begin
      if (h_last) begin
        sx_d = '0;
        sy_d = v_last ? '0 : sy_q + 10'd1;
      end else begin
        sx_d = sx_q + 10'd1;
      end
    end
  end

  // Decoded straight from the counter registers so they line up with sx/sy.
  always_comb begin
    de    = (sx_q < HActive) && (sy_q < VActive);
    hsync = !((sx_q >= HSyncBeg) && (sx_q < HSyncEnd));
    vsync = !((sy_q >= VSyncBeg) && (sy_q < VSyncEnd));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else begin
      div_q <= div_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
    end
  end

`ifdef VGA_DOUBLE_BUFFER_EN
  logic        pend_valid_q, pend_valid_d;
  logic [47:0] pend_q, pend_d;

  // A slot filled during the wrap cycle was empty before the edge, so it is not applied there.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    concat_d     = concat_q;
    if (frame_start && pend_valid_q) begin
      concat_d     = pend_q;
      pend_valid_d = 1'b0;
    end
    if (numbers_valid && !pend_valid_q) begin
      pend_d       = numbers_in;
      pend_valid_d = 1'b1;
    end
  end

  assign numbers_ready = !pend_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      concat_q     <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      concat_q     <= concat_d;
    end
  end
`else
  always_comb begin
    concat_d = numbers_valid ? numbers_in : concat_q;
  end

  assign numbers_ready = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      concat_q <= '0;
    end else begin
      concat_q <= concat_d;
    end
  end
`endif

  assign sx             = sx_q;
  assign sy             = sy_q;
  assign numbers_concat = concat_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default-timing instance for line checks, a tiny-timing
// instance for frame, handshake and asynchronous reset checks.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_s;
  logic [47:0] num_in, num_in_s;
  logic        num_valid, num_valid_s;

  logic        ready, de, hsync, vsync, pix_stb, frame_start;
  logic [9:0]  sx, sy;
  logic [47:0] concat;

  logic        ready_s, de_s, hsync_s, vsync_s, pix_stb_s, frame_start_s;
  logic [9:0]  sx_s, sy_s;
  logic [47:0] concat_s;

  int tests_run    = 0;
  int tests_failed = 0;

  vga_timing dut (
    .clk            (clk),
    .rst            (rst),
    .numbers_in     (num_in),
    .numbers_valid  (num_valid),
    .numbers_ready  (ready),
    .sx             (sx),
    .sy             (sy),
    .de             (de),
    .hsync          (hsync),
    .vsync          (vsync),
    .pix_stb        (pix_stb),
    .frame_start    (frame_start),
    .numbers_concat (concat)
  );

  // 2 clk/pixel, 15 pixels/line (hsync sx 10..12), 11 lines/frame (vsync sy 7..8): 330 clk/frame.
  vga_timing #(
    .CLK_DIV  (2),
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (2),
    .V_ACTIVE (6),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (2)
  ) dut_s (
    .clk            (clk),
    .rst            (rst_s),
    .numbers_in     (num_in_s),
    .numbers_valid  (num_valid_s),
    .numbers_ready  (ready_s),
    .sx             (sx_s),
    .sy             (sy_s),
    .de             (de_s),
    .hsync          (hsync_s),
    .vsync          (vsync_s),
    .pix_stb        (pix_stb_s),
    .frame_start    (frame_start_s),
    .numbers_concat (concat_s)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_fs_s(input string tag);
    int n = 0;
    while (!frame_start_s && n < 1000) begin
      step();
      n++;
    end
    check_eq(tag, 64'(frame_start_s), 64'd1);
  endtask

  initial begin
    int n;
    int hs_cnt, hs_first, hs_last, de_last, de_fall, sx_max;
    int vs_first, vs_last, vs_pix;

    rst = 1'b1;  rst_s = 1'b1;
    num_in = '0; num_in_s = '0;
    num_valid = 1'b0; num_valid_s = 1'b0;
    repeat (3) step();

    // Reset state of the default instance: {sx, sy, stb, fs, de, hs, vs, ready}
    check_eq("rst_vec", 64'({sx, sy, pix_stb, frame_start, de, hsync, vsync, ready}),
             64'({10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}));
    check_eq("rst_concat", 64'(concat), 64'd0);

    rst = 1'b0;
    step();
    check_eq("stb_clk1", 64'(pix_stb), 64'd0);
    step();
    check_eq("stb_clk2", 64'(pix_stb), 64'd0);
    step();
    check_eq("stb_clk4", 64'(pix_stb), 64'd1);
    check_eq("sx_pre_stb", 64'(sx), 64'd0);
    step();
    check_eq("sx_after_stb", 64'(sx), 64'd1);
    check_eq("stb_low", 64'(pix_stb), 64'd0);
    repeat (3) step();
    check_eq("stb_period", 64'(pix_stb), 64'd1);

    // Scan line 0 of the default instance.
    hs_cnt = 0; hs_first = -1; hs_last = -1; de_last = -1; de_fall = -1; sx_max = -1;
    n = 0;
    while (sy != 10'd1 && n < 4000) begin
      if (sy == 10'd0) begin
        if (pix_stb && !hsync) hs_cnt++;
        if (!hsync) begin
          if (hs_first < 0) hs_first = int'(sx);
          hs_last = int'(sx);
        end
        if (de) de_last = int'(sx);
        if (!de && de_fall < 0) de_fall = int'(sx);
        sx_max = int'(sx);
      end
      step();
      n++;
    end
    check_eq("line_wrap_sy", 64'(sy), 64'd1);
    check_eq("line_wrap_sx", 64'(sx), 64'd0);
    check_eq("sx_max", 64'(sx_max), 64'd799);
    check_eq("de_last", 64'(de_last), 64'd639);
    check_eq("de_fall", 64'(de_fall), 64'd640);
    check_eq("hs_first", 64'(hs_first), 64'd656);
    check_eq("hs_last", 64'(hs_last), 64'd751);
    check_eq("hs_pixels", 64'(hs_cnt), 64'd96);

    // Small instance: frame period and vsync window.
    rst_s = 1'b0;
    wait_fs_s("fs_first");
    vs_first = -1; vs_last = -1; vs_pix = 0;
    step();
    n = 1;
    while (!frame_start_s && n < 1000) begin
      if (!vsync_s) begin
        if (vs_first < 0) vs_first = int'(sy_s);
        vs_last = int'(sy_s);
        if (pix_stb_s) vs_pix++;
      end
      step();
      n++;
    end
    check_eq("frame_period", 64'(n), 64'd330);
    check_eq("vs_first", 64'(vs_first), 64'd7);
    check_eq("vs_last", 64'(vs_last), 64'd8);
    check_eq("vs_pixels", 64'(vs_pix), 64'd30);

    // Offer a word mid-frame.
    step();
    n = 0;
    while (sy_s != 10'd3 && n < 1000) begin
      step();
      n++;
    end
    check_eq("reach_sy3", 64'(sy_s), 64'd3);
    check_eq("ready_pre", 64'(ready_s), 64'd1);
    num_in_s = 48'h0123456789AB;
    num_valid_s = 1'b1;
    step();
    num_valid_s = 1'b0;
`ifdef VGA_DOUBLE_BUFFER_EN
    check_eq("ready_after_acc", 64'(ready_s), 64'd0);
    check_eq("concat_held", 64'(concat_s), 64'd0);
    wait_fs_s("fs_apply");
    check_eq("concat_pre_wrap", 64'(concat_s), 64'd0);
    step();
    check_eq("concat_applied", 64'(concat_s), 64'h0123456789AB);
    check_eq("ready_back", 64'(ready_s), 64'd1);
`else
    check_eq("ready_tied", 64'(ready_s), 64'd1);
    check_eq("concat_direct", 64'(concat_s), 64'h0123456789AB);
    wait_fs_s("fs_apply");
    step();
    check_eq("concat_kept", 64'(concat_s), 64'h0123456789AB);
`endif

    // Offer a word in the frame_start cycle.
    wait_fs_s("fs_late");
    num_in_s = 48'hAAAAAAAAAAAA;
    num_valid_s = 1'b1;
    step();
    num_valid_s = 1'b0;
`ifdef VGA_DOUBLE_BUFFER_EN
    check_eq("late_not_applied", 64'(concat_s), 64'h0123456789AB);
    check_eq("late_ready_low", 64'(ready_s), 64'd0);
    wait_fs_s("fs_late_next");
    step();
    check_eq("late_applied", 64'(concat_s), 64'hAAAAAAAAAAAA);
    check_eq("late_ready_back", 64'(ready_s), 64'd1);
`else
    check_eq("late_direct", 64'(concat_s), 64'hAAAAAAAAAAAA);
`endif

    // Asynchronous reset with a word pending.
    n = 0;
    while (!(sx_s == 10'd5 && sy_s == 10'd4) && n < 1000) begin
      step();
      n++;
    end
    check_eq("reach_mid", 64'({sx_s, sy_s}), 64'({10'd5, 10'd4}));
    num_in_s = 48'h555555555555;
    num_valid_s = 1'b1;
    step();
    num_valid_s = 1'b0;
    #2 rst_s = 1'b1;
    #1;
    check_eq("arst_vec", 64'({sx_s, sy_s, pix_stb_s, frame_start_s, de_s, hsync_s, vsync_s,
                              ready_s}),
             64'({10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}));
    check_eq("arst_concat", 64'(concat_s), 64'd0);
    step();
    step();
    rst_s = 1'b0;
    wait_fs_s("fs_post_rst");
    step();
    check_eq("pend_dropped", 64'(concat_s), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
